// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_e;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin on ties, whole-cycle grants,
// one dead cycle between grants, bus error after TIMEOUT unacked strobe cycles.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  arb_state_e        state_q, state_d;
  master_e           last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  master_e owner;
  logic    own_cyc, own_stb;

  assign owner   = (state_q == ST_GNT1) ? MST_M1 : MST_M0;
  assign own_cyc = (owner == MST_M1) ? m1_cyc_i : m0_cyc_i;
  assign own_stb = (owner == MST_M1) ? m1_stb_i : m0_stb_i;

  // ERR records its owner in last_gnt on entry, so the error pulse knows
  // which master to terminate and the following IDLE sees the same history.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (m0_cyc_i && m1_cyc_i)
          state_d = (last_gnt_q == MST_M1) ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)
          state_d = ST_GNT0;
        else if (m1_cyc_i)
          state_d = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        if (!own_cyc) begin
          state_d    = ST_IDLE;
          last_gnt_d = owner;
          cnt_d      = '0;
        end else if (own_stb && !s_ack_i && (cnt_q >= CNT_W'(TIMEOUT))) begin
          state_d    = ST_ERR;
          last_gnt_d = owner;
          cnt_d      = '0;
        end else if (!own_stb || s_ack_i) begin
          cnt_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= MST_M1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = GNT_NONE;
    unique case (state_q)
      ST_GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
        gnt_o    = GNT_M0;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
        gnt_o    = GNT_M1;
      end
      ST_ERR: begin
        m0_err_o = (last_gnt_q == MST_M0);
        m1_err_o = (last_gnt_q == MST_M1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (TIMEOUT = 8).
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  gnt_o;

  int n_run  = 0;
  int n_fail = 0;

  wb_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {s_cyc, s_stb, gnt[1:0], m0_ack, m0_err, m1_ack, m1_err}
  function automatic logic [7:0] ctl();
    return {s_cyc_o, s_stb_o, gnt_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    m0_adr_i = 32'h1234_5678; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
    #2;
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL reset_ctl got %b exp %b", ctl(), 8'h00); end
    n_run++; if (s_adr_o !== 32'h0) begin n_fail++; $display("FAIL reset_adr got %h exp %h", s_adr_o, 32'h0); end
    tick(); tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL reset_hold got %b exp %b", ctl(), 8'h00); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0; m0_adr_i = '0;
    tick(); rst_i = 1'b1;
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL reset_release got %b exp %b", ctl(), 8'h00); end
  endtask

  task automatic test_single_read();
    m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF; m0_we_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL rd_latency got %b exp %b", ctl(), 8'h00); end
    tick(); settle();
    n_run++; if (ctl() !== 8'b1101_0000) begin n_fail++; $display("FAIL rd_grant got %b exp %b", ctl(), 8'b1101_0000); end
    n_run++; if (s_adr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL rd_adr got %h exp %h", s_adr_o, 32'h1000); end
    tick(); settle();
    n_run++; if (ctl() !== 8'b1101_0000) begin n_fail++; $display("FAIL rd_wait got %b exp %b", ctl(), 8'b1101_0000); end
    tick(); s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; settle();
    n_run++; if (ctl() !== 8'b1101_1000) begin n_fail++; $display("FAIL rd_ack got %b exp %b", ctl(), 8'b1101_1000); end
    n_run++; if (m0_dat_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h exp %h", m0_dat_o, 32'hDEADBEEF); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0; settle();
    n_run++; if (ctl() !== 8'b0001_0000) begin n_fail++; $display("FAIL rd_drop got %b exp %b", ctl(), 8'b0001_0000); end
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL rd_idle got %b exp %b", ctl(), 8'h00); end
  endtask

  task automatic test_tie();
    rst_i = 1'b0; tick(); rst_i = 1'b1;
    m0_adr_i = 32'hA0; m1_adr_i = 32'hB0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); settle();
    n_run++; if (ctl() !== 8'b1101_0000) begin n_fail++; $display("FAIL tie_first got %b exp %b", ctl(), 8'b1101_0000); end
    n_run++; if (s_adr_o !== 32'hA0) begin n_fail++; $display("FAIL tie_adr0 got %h exp %h", s_adr_o, 32'hA0); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL tie_dead got %b exp %b", ctl(), 8'h00); end
    tick(); settle();
    n_run++; if (ctl() !== 8'b1110_0000) begin n_fail++; $display("FAIL tie_second got %b exp %b", ctl(), 8'b1110_0000); end
    n_run++; if (s_adr_o !== 32'hB0) begin n_fail++; $display("FAIL tie_adr1 got %h exp %h", s_adr_o, 32'hB0); end
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL tie_dead2 got %b exp %b", ctl(), 8'h00); end
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); settle();
    n_run++; if (ctl() !== 8'b1101_0000) begin n_fail++; $display("FAIL tie_rr got %b exp %b", ctl(), 8'b1101_0000); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL tie_end got %b exp %b", ctl(), 8'h00); end
  endtask

  task automatic test_burst();
    m1_adr_i = 32'h2000; m1_dat_i = 32'h5555_0000; m1_sel_i = 4'h3; m1_we_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); settle();
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 1'b1; s_dat_i = 32'hC0DE_0000 + 32'(i); settle();
      n_run++; if (ctl() !== 8'b1110_0010) begin n_fail++; $display("FAIL burst_beat%0d got %b exp %b", i, ctl(), 8'b1110_0010); end
      n_run++; if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !== {32'h2000 + 32'(4 * i), m1_dat_i, 4'h3, 1'b1})
        begin n_fail++; $display("FAIL burst_bus%0d got %h/%h exp %h/%h", i, s_adr_o, s_dat_o, 32'h2000 + 32'(4 * i), m1_dat_i); end
      n_run++; if (m1_dat_o !== 32'hC0DE_0000 + 32'(i)) begin n_fail++; $display("FAIL burst_rdata%0d got %h exp %h", i, m1_dat_o, 32'hC0DE_0000 + 32'(i)); end
      if (i == 1) begin m0_adr_i = 32'h4000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
      m1_adr_i = m1_adr_i + 32'd4; m1_dat_i = m1_dat_i + 32'd1;
      tick();
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0; settle();
    n_run++; if (ctl() !== 8'b0010_0000) begin n_fail++; $display("FAIL burst_drop got %b exp %b", ctl(), 8'b0010_0000); end
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL burst_dead got %b exp %b", ctl(), 8'h00); end
    tick(); settle();
    n_run++; if (ctl() !== 8'b1101_0000) begin n_fail++; $display("FAIL burst_m0 got %b exp %b", ctl(), 8'b1101_0000); end
    s_ack_i = 1'b1; settle();
    n_run++; if (ctl() !== 8'b1101_1000) begin n_fail++; $display("FAIL burst_m0ack got %b exp %b", ctl(), 8'b1101_1000); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick(); settle();
      n_run++; if (ctl() !== 8'b1101_0000) begin n_fail++; $display("FAIL to_wait%0d got %b exp %b", k, ctl(), 8'b1101_0000); end
    end
    tick(); s_ack_i = 1'b1; settle();
    n_run++; if (ctl() !== 8'b0000_0100) begin n_fail++; $display("FAIL to_err got %b exp %b", ctl(), 8'b0000_0100); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL to_idle got %b exp %b", ctl(), 8'h00); end
    s_ack_i = 1'b0;
  endtask

  task automatic test_ack_at_limit();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); settle();
      n_run++; if (ctl() !== 8'b1101_0000) begin n_fail++; $display("FAIL lim_wait%0d got %b exp %b", k, ctl(), 8'b1101_0000); end
    end
    tick(); s_ack_i = 1'b1; s_dat_i = 32'h0000_600D; settle();
    n_run++; if (ctl() !== 8'b1101_1000) begin n_fail++; $display("FAIL lim_ack got %b exp %b", ctl(), 8'b1101_1000); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL lim_noerr got %b exp %b", ctl(), 8'h00); end
    tick(); settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL lim_idle got %b exp %b", ctl(), 8'h00); end
  endtask

  task automatic test_reset_mid();
    m1_adr_i = 32'h3000; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); settle();
    n_run++; if (ctl() !== 8'b1110_0000) begin n_fail++; $display("FAIL rst_mid_gnt got %b exp %b", ctl(), 8'b1110_0000); end
    #2 rst_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
    #1;
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL rst_mid_async got %b exp %b", ctl(), 8'h00); end
    n_run++; if (s_adr_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_adr got %h exp %h", s_adr_o, 32'h0); end
    s_ack_i = 1'b0;
    tick(); rst_i = 1'b1; settle();
    n_run++; if (ctl() !== 8'h00) begin n_fail++; $display("FAIL rst_mid_rel got %b exp %b", ctl(), 8'h00); end
    tick(); settle();
    n_run++; if (ctl() !== 8'b1101_0000) begin n_fail++; $display("FAIL rst_mid_tie got %b exp %b", ctl(), 8'b1101_0000); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
  endtask

  initial begin
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0;
    test_reset();
    test_single_read();
    test_tie();
    test_burst();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
